// File: rtl/mstr_arb.sv
// mstr_arb: two-master round-robin arbiter onto one downstream port; bus timeout enabled by MSTR_ARB_TIMEOUT_EN
module mstr_arb #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_valid_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,
    input  logic        m1_valid_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,
    output logic        core_valid_o,
    output logic [31:0] core_addr_o,
    output logic [31:0] core_wdata_o,
    output logic [3:0]  core_wstrb_o,
    input  logic [31:0] core_rdata_i,
    input  logic        core_ready_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
    state_t state, state_nxt;
    logic last, g0, g1, busy, own_valid, tmo, done;
    logic [31:0] rdata;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_range
        $error("mstr_arb: TIMEOUT_CYC must be in 2..65535");
    end

    assign g0        = state == BUSY0;
    assign g1        = state == BUSY1;
    assign busy      = g0 || g1;
    assign own_valid = g0 ? m0_valid_i : m1_valid_i;
    assign done      = busy && (core_ready_i || tmo);

`ifdef MSTR_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    // unanswered busy cycles; the mandatory idle cycle clears it before every grant
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else
            cnt <= (busy && !core_ready_i) ? cnt + 16'd1 : '0;
    end
    assign tmo = busy && !core_ready_i && cnt == 16'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif

    // state register and round-robin pointer; last remembers who completed most recently
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (done)
                last <= g1;
        end
    end

    // arbitrate only from idle; a tie goes to the master not served last
    always_comb begin
        state_nxt = state == IDLE ? ((m0_valid_i && m1_valid_i) ? (last ? BUSY0 : BUSY1) :
                                     m0_valid_i ? BUSY0 : m1_valid_i ? BUSY1 : IDLE) :
                    (!busy || done || !own_valid) ? IDLE : state;
    end

    // downstream mux from the owner; responses only reach the owner, zero everywhere when idle
    always_comb begin
        core_valid_o = g0 ? m0_valid_i : g1 ? m1_valid_i : 1'b0;
        core_addr_o  = g0 ? m0_addr_i  : g1 ? m1_addr_i  : '0;
        core_wdata_o = g0 ? m0_wdata_i : g1 ? m1_wdata_i : '0;
        core_wstrb_o = g0 ? m0_wstrb_i : g1 ? m1_wstrb_i : '0;
        rdata        = core_ready_i ? core_rdata_i : tmo ? 32'hDEAD_BEEF : '0;
        m0_ready_o   = g0 && done;
        m1_ready_o   = g1 && done;
        m0_rdata_o   = (g0 && done) ? rdata : '0;
        m1_rdata_o   = (g1 && done) ? rdata : '0;
        grant_o      = {g1, g0};
        err_o        = tmo;
    end
endmodule

// File: tb/tb_mstr_arb.sv
// tb_mstr_arb: vector table, directed corner sequences and randomized run against a transaction-level model
module tb_mstr_arb;
    localparam int T = 8;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic        m0_valid_i = 1'b0, m1_valid_i = 1'b0, core_ready_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_wdata_i = '0, m1_addr_i = '0, m1_wdata_i = '0, core_rdata_i = '0;
    logic [3:0]  m0_wstrb_i = '0, m1_wstrb_i = '0;
    logic [31:0] m0_rdata_o, m1_rdata_o, core_addr_o, core_wdata_o;
    logic [3:0]  core_wstrb_o;
    logic        m0_ready_o, m1_ready_o, core_valid_o, err_o;
    logic [1:0]  grant_o;

    int n_run = 0, n_fail = 0;
    int m_owner = -1, m_last = 0, m_age = 0;

    typedef struct {
        bit m0v, m1v, cr;
        logic [1:0] g;
        bit cv, r0, r1;
    } vec_t;
    vec_t tbl[11];
    int served[$];

    mstr_arb #(.TIMEOUT_CYC(T)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
        .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
        .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
        .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
        .core_valid_o(core_valid_o), .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
        .core_wstrb_o(core_wstrb_o), .core_rdata_i(core_rdata_i), .core_ready_i(core_ready_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        {m0_valid_i, m1_valid_i, core_ready_i} = '0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        m_owner = -1; m_last = 0; m_age = 0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_grant"}, 32'(grant_o), 0);
        chk({nm, "_cvalid"}, 32'(core_valid_o), 0);
        chk({nm, "_caddr"}, core_addr_o, 0);
        chk({nm, "_cwdata"}, core_wdata_o, 0);
        chk({nm, "_cwstrb"}, 32'(core_wstrb_o), 0);
        chk({nm, "_rdy"}, 32'({m1_ready_o, m0_ready_o}), 0);
        chk({nm, "_rdata"}, m0_rdata_o | m1_rdata_o, 0);
        chk({nm, "_err"}, 32'(err_o), 0);
    endtask

    // transaction-level model: who owns the bus, who finished last, how long the owner has waited
    task automatic model_cycle();
        logic v[2];
        logic [31:0] a[2], w[2], rd[2];
        logic [3:0] s[2];
        logic rdy[2];
        bit fin, to;
        v = '{m0_valid_i, m1_valid_i};
        a = '{m0_addr_i, m1_addr_i};
        w = '{m0_wdata_i, m1_wdata_i};
        s = '{m0_wstrb_i, m1_wstrb_i};
        rd = '{m0_rdata_o, m1_rdata_o};
        rdy = '{m0_ready_o, m1_ready_o};
        fin = m_owner >= 0 && core_ready_i;
        to = 1'b0;
`ifdef MSTR_ARB_TIMEOUT_EN
        to = m_owner >= 0 && !core_ready_i && m_age == T - 1;
`endif
        chk("rnd_grant", 32'(grant_o), m_owner < 0 ? 0 : 1 << m_owner);
        chk("rnd_cvalid", 32'(core_valid_o), m_owner < 0 ? 0 : 32'(v[m_owner]));
        chk("rnd_caddr", core_addr_o, m_owner < 0 ? 0 : a[m_owner]);
        chk("rnd_cwdata", core_wdata_o, m_owner < 0 ? 0 : w[m_owner]);
        chk("rnd_cwstrb", 32'(core_wstrb_o), m_owner < 0 ? 0 : 32'(s[m_owner]));
        chk("rnd_err", 32'(err_o), 32'(to));
        for (int i = 0; i < 2; i++) begin
            chk("rnd_ready", 32'(rdy[i]), 32'(m_owner == i && (fin || to)));
            if (m_owner != i)
                chk("rnd_rdata_idle", rd[i], 0);
            else if (fin)
                chk("rnd_rdata", rd[i], core_rdata_i);
            else if (to)
                chk("rnd_rdata_to", rd[i], 32'hDEAD_BEEF);
        end
        if (m_owner < 0) begin
            m_owner = (v[0] && v[1]) ? 1 - m_last : v[0] ? 0 : v[1] ? 1 : -1;
            m_age = 0;
        end else if (fin || to) begin
            m_last = m_owner;
            m_owner = -1;
        end else if (!v[m_owner])
            m_owner = -1;
        else
            m_age++;
    endtask

    initial begin
        tbl = '{
            '{1, 1, 0, 2'b00, 0, 0, 0},
            '{1, 1, 0, 2'b10, 1, 0, 0},
            '{1, 1, 1, 2'b10, 1, 0, 1},
            '{1, 1, 0, 2'b00, 0, 0, 0},
            '{1, 1, 1, 2'b01, 1, 1, 0},
            '{0, 1, 1, 2'b00, 0, 0, 0},
            '{0, 0, 0, 2'b10, 0, 0, 0},
            '{1, 0, 0, 2'b00, 0, 0, 0},
            '{1, 1, 0, 2'b01, 1, 0, 0},
            '{1, 1, 1, 2'b01, 1, 1, 0},
            '{0, 0, 0, 2'b00, 0, 0, 0}
        };
        #1;
        check_all_zero("reset");
        do_reset();

        m0_addr_i = 32'h1000_0000; m1_addr_i = 32'h2000_0000;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            m0_valid_i = tbl[i].m0v; m1_valid_i = tbl[i].m1v; core_ready_i = tbl[i].cr;
            core_rdata_i = 32'h5A5A_0000 | 32'(i);
            #1;
            chk("tbl_grant", 32'(grant_o), 32'(tbl[i].g));
            chk("tbl_cvalid", 32'(core_valid_o), 32'(tbl[i].cv));
            chk("tbl_ready", 32'({m1_ready_o, m0_ready_o}), 32'({tbl[i].r1, tbl[i].r0}));
            if (tbl[i].r0) chk("tbl_rdata0", m0_rdata_o, core_rdata_i);
            if (!tbl[i].g[0]) chk("tbl_rdata0_zero", m0_rdata_o, 0);
            if (tbl[i].r1) chk("tbl_rdata1", m1_rdata_o, core_rdata_i);
            if (!tbl[i].g[1]) chk("tbl_rdata1_zero", m1_rdata_o, 0);
        end

        do_reset();
        m0_addr_i = 32'h0300_0000; m0_wdata_i = 32'h1234_5678; m0_wstrb_i = 4'hF;
        begin
            int pulses = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                m0_valid_i = k < 4; core_ready_i = k == 3;
                #1;
                if (k == 0) chk("wr_cvalid_lat", 32'(core_valid_o), 0);
                if (k == 1) begin
                    chk("wr_cvalid", 32'(core_valid_o), 1);
                    chk("wr_caddr", core_addr_o, 32'h0300_0000);
                    chk("wr_cwdata", core_wdata_o, 32'h1234_5678);
                    chk("wr_cwstrb", 32'(core_wstrb_o), 32'hF);
                    chk("wr_grant", 32'(grant_o), 1);
                end
                if (k == 3) chk("wr_ready", 32'(m0_ready_o), 1);
                if (k == 4) chk("wr_grant_idle", 32'(grant_o), 0);
                pulses += int'(m0_ready_o);
            end
            chk("wr_pulses", pulses, 1);
        end

        do_reset();
        m1_wstrb_i = 4'h0; core_rdata_i = 32'hCAFE_0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            m1_valid_i = 1'b1; core_ready_i = k == 2;
            #1;
            if (k == 2) begin
                chk("rd_ready1", 32'(m1_ready_o), 1);
                chk("rd_rdata1", m1_rdata_o, 32'hCAFE_0001);
            end
            chk("rd_rdata0", m0_rdata_o, 0);
            chk("rd_ready0", 32'(m0_ready_o), 0);
        end

        do_reset();
        served.delete();
        for (int k = 0; k < 40 && served.size() < 6; k++) begin
            @(negedge clk_i);
            m0_valid_i = 1'b1; m1_valid_i = 1'b1; core_ready_i = 1'b1;
            #1;
            if (m0_ready_o) served.push_back(0);
            if (m1_ready_o) served.push_back(1);
        end
        chk("alt_count", served.size(), 6);
        for (int i = 0; i < served.size() && i < 6; i++)
            chk("alt_order", served[i], (i % 2 == 0) ? 1 : 0);

        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk_i);
            m0_valid_i = 1'b1; core_ready_i = 1'b0;
            #1;
`ifdef MSTR_ARB_TIMEOUT_EN
            chk("to_err", 32'(err_o), 32'(k == 8));
            chk("to_ready", 32'(m0_ready_o), 32'(k == 8));
            if (k == 8) chk("to_rdata", m0_rdata_o, 32'hDEAD_BEEF);
            if (k == 9) chk("to_cvalid_after", 32'(core_valid_o), 0);
`else
            chk("hold_err", 32'(err_o), 0);
            chk("hold_ready", 32'(m0_ready_o), 0);
            if (k >= 1) chk("hold_grant", 32'(grant_o), 1);
`endif
        end

        do_reset();
        @(negedge clk_i);
        m1_valid_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_busy1", 32'(grant_o), 2);
        #1;
        core_ready_i = 1'b1; rst_n_i = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk_i);
        check_all_zero("rst_held");
        rst_n_i = 1'b1; core_ready_i = 1'b0; m0_valid_i = 1'b1; m1_valid_i = 1'b1;
        #1;
        chk("rst_rel_idle", 32'(grant_o), 0);
        @(negedge clk_i);
        #1;
        chk("rst_rel_grant", 32'(grant_o), 2);

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_i);
            m0_valid_i = $urandom_range(3) != 0;
            m1_valid_i = $urandom_range(3) != 0;
            core_ready_i = $urandom_range(3) == 0;
            m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_wstrb_i = 4'($urandom);
            m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_wstrb_i = 4'($urandom);
            core_rdata_i = $urandom;
            #1;
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mstr_arb.md
MSTR_ARB -- requirements
Module: mstr_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 1024, bus-timeout limit in clk_i cycles (MSTR_ARB_TIMEOUT_EN only), legal range 2..65535.
REQ-002 SHALL have ports, one per line:
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- m0_valid_i  in  1  master 0 (mgmt) request.
- m0_addr_i  in  32  master 0 address.
- m0_wdata_i  in  32  master 0 write data.
- m0_wstrb_i  in  4  master 0 byte strobes; 0 = read.
- m0_rdata_o  out  32  master 0 read data.
- m0_ready_o  out  1  master 0 completion pulse.
- m1_* (valid_i, addr_i, wdata_i, wstrb_i, rdata_o, ready_o)  same widths  master 1 (user).
- core_valid_o  out  1  downstream request.
- core_addr_o  out  32  downstream address.
- core_wdata_o  out  32  downstream write data.
- core_wstrb_o  out  4  downstream strobes.
- core_rdata_i  in  32  downstream read data.
- core_ready_i  in  1  downstream completion.
- grant_o  out  2  one-hot current owner; 00 = idle.
- err_o  out  1  one-cycle timeout pulse.
REQ-003 Clock is clk_i; reset is rst_n_i, asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, BUSY0, BUSY1.
REQ-005 In IDLE, only m0 valid SHALL go to BUSY0; only m1 valid SHALL go to BUSY1; neither SHALL stay in IDLE.
REQ-006 In IDLE with both valid, the master not served last SHALL win (round-robin via 1-bit last pointer, reset value 0, so m1 wins first tie).
REQ-007 Arbitration latency SHALL be one cycle: core_valid_o first asserts in the cycle after valid is sampled in IDLE.
REQ-008 In BUSYx, core_valid_o SHALL equal mx_valid_i; addr/wdata/wstrb SHALL be combinationally muxed from master x.
REQ-009 In IDLE, core_valid_o, core_addr_o, core_wdata_o and core_wstrb_o SHALL be 0.
REQ-010 In BUSYx with core_ready_i=1, mx_ready_o SHALL be 1 and mx_rdata_o SHALL equal core_rdata_i in the same cycle; FSM SHALL go to IDLE and last SHALL be set to x.
REQ-011 The non-granted master SHALL see ready_o=0 and rdata_o=0 at all times; core_ready_i in IDLE SHALL be ignored.
REQ-012 If the granted master drops valid in BUSYx before ready, FSM SHALL return to IDLE with no ready and last unchanged.
REQ-013 Grant SHALL never change mid-transaction; a new request arriving in BUSYx SHALL wait for IDLE.
REQ-014 Back-to-back: IDLE is mandatory between transactions (one bubble cycle), giving a fair alternation under continuous contention.
REQ-015 grant_o SHALL be 01 in BUSY0, 10 in BUSY1, 00 in IDLE.

Reset
REQ-016 On rst_n_i low, FSM SHALL be IDLE, last=0, timeout counter=0, and every output SHALL be 0, independent of clk_i.
REQ-017 Reset asserted mid-transaction SHALL abort it without any ready pulse; first grant after release follows REQ-005/006.

Configuration
REQ-018 Macro MSTR_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to BUSYx and increment each BUSYx cycle without core_ready_i; when it reaches TIMEOUT_CYC-1, mx_ready_o=1, mx_rdata_o=32'hDEAD_BEEF, err_o=1 for that cycle, core_valid_o SHALL be 0 in the following cycle, and FSM SHALL go to IDLE with last=x.
REQ-019 core_ready_i in the same cycle as timeout SHALL win: normal completion, no err_o.
REQ-020 Macro undefined: no counter, BUSYx waits indefinitely, err_o tied 0.

Verification
REQ-021 m0 write addr 0x0300_0000 data 0x1234_5678 wstrb 0xF, ready after 3 cycles -> core_valid_o one cycle after request, m0_ready_o single pulse, grant_o 01 then 00.
REQ-022 m0 and m1 valid together from reset -> m1 served first, then m0; grant_o 10, 00, 01.
REQ-023 Both continuously requesting 6 transactions -> strict alternation m1,m0,m1,m0,m1,m0; no starvation.
REQ-024 m1 read, core_rdata_i=0xCAFE_0001 -> m1_rdata_o=0xCAFE_0001 with m1_ready_o; m0_rdata_o stays 0.
REQ-025 MSTR_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, core_ready_i never asserted -> after 8 BUSY cycles m0_ready_o=1, rdata 0xDEAD_BEEF, err_o pulse; without macro -> grant held, err_o 0.
REQ-026 rst_n_i low during BUSY1 -> all outputs 0 immediately, no m1_ready_o; after release new requests arbitrate normally.
